// File: rtl/probe_buffer_arbiter_pkg.sv
// Shared types and header layout for the probe buffer arbiter.
// The header word carries a tag, the source id and the running data-word count.
package probe_buffer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hB0F0;

  localparam int HDR_MAGIC_LSB = 48;
  localparam int HDR_SRC_LSB   = 40;
  localparam int HDR_RSVD_LSB  = 32;
  localparam int HDR_COUNT_LSB = 0;

  function automatic logic [63:0] make_header(input logic [15:0] magic,
                                              input logic [7:0]  src,
                                              input logic [31:0] count);
    logic [63:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: 16] = magic;
    h[HDR_SRC_LSB   +: 8]  = src;
    h[HDR_RSVD_LSB  +: 8]  = 8'h00;
    h[HDR_COUNT_LSB +: 32] = count;
    return h;
  endfunction

endpackage

// File: rtl/probe_buffer_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index strictly after ptr,
// wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDXW-1:0]    ptr,
  output logic               any,
  output logic [IDXW-1:0]    index
);

  logic [IDXW-1:0] cand_idx [NUM_REQ];

  // cand_idx[gi] is the requester examined at priority position gi
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDXW:0] sum;
      assign sum = {1'b0, ptr} + (IDXW+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (IDXW+1)'(NUM_REQ)) ?
                            IDXW'(sum - (IDXW+1)'(NUM_REQ)) : sum[IDXW-1:0];
    end
  endgenerate

  always_comb begin
    any   = 1'b0;
    index = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (valid[cand_idx[k]]) begin
        any   = 1'b1;
        index = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/probe_buffer_arbiter.sv
// Round-robin arbiter funnelling probe words from NUM_REQ requesters into one
// probe-buffer write port, prefixing a header whenever the source changes.
module probe_buffer_arbiter
  import probe_buffer_arbiter_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter int          MAX_BURST = 8,
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*64-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   pb_wen,
  output logic [63:0]            pb_write,
  output logic [31:0]            word_count
);

  localparam int         IDXW       = $clog2(NUM_REQ);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t          state_reg, state_next;
  logic [IDXW-1:0] grant_reg, grant_next;
  logic [IDXW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [IDXW-1:0] last_src_reg, last_src_next;
  logic            last_valid_reg, last_valid_next;
  logic [7:0]      burst_cnt_reg, burst_cnt_next;
  logic [31:0]     word_count_reg, word_count_next;
  logic            pb_wen_reg, pb_wen_next;
  logic [63:0]     pb_write_reg, pb_write_next;

  logic [NUM_REQ-1:0] ready_int;
  logic               end_burst;
  logic               pick_any;
  logic [IDXW-1:0]    pick_idx;
  logic [63:0]        req_word [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign req_word[gi] = req_data[64*gi +: 64];
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr_reg),
    .any   (pick_any),
    .index (pick_idx)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= '0;
      rr_ptr_reg     <= IDXW'(NUM_REQ - 1);
      last_src_reg   <= '0;
      last_valid_reg <= 1'b0;
      burst_cnt_reg  <= '0;
      word_count_reg <= '0;
      pb_wen_reg     <= 1'b0;
      pb_write_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      rr_ptr_reg     <= rr_ptr_next;
      last_src_reg   <= last_src_next;
      last_valid_reg <= last_valid_next;
      burst_cnt_reg  <= burst_cnt_next;
      word_count_reg <= word_count_next;
      pb_wen_reg     <= pb_wen_next;
      pb_write_reg   <= pb_write_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    rr_ptr_next     = rr_ptr_reg;
    last_src_next   = last_src_reg;
    last_valid_next = last_valid_reg;
    burst_cnt_next  = burst_cnt_reg;
    word_count_next = word_count_reg;
    pb_wen_next     = 1'b0;
    pb_write_next   = pb_write_reg;
    ready_int       = '0;
    end_burst       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (enable && pick_any) begin
          grant_next = pick_idx;
          // Continuing the same source needs no new header
          state_next = (!last_valid_reg || pick_idx != last_src_reg) ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        pb_wen_next   = 1'b1;
        pb_write_next = make_header(HDR_MAGIC, 8'(grant_reg), word_count_reg);
        state_next    = ST_DATA;
      end
      ST_DATA: begin
        ready_int[grant_reg] = enable;
        if (enable && req_valid[grant_reg]) begin
          pb_wen_next     = 1'b1;
          pb_write_next   = req_word[grant_reg];
          word_count_next = word_count_reg + 32'd1;
          if (burst_cnt_reg == BURST_LAST) begin
            end_burst = 1'b1;
          end else begin
            burst_cnt_next = burst_cnt_reg + 8'd1;
          end
        end else begin
          end_burst = 1'b1;
        end
        if (end_burst) begin
          state_next      = ST_IDLE;
          rr_ptr_next     = grant_reg;
          last_src_next   = grant_reg;
          last_valid_next = 1'b1;
          burst_cnt_next  = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Nothing may be consumed while reset is held, whatever the state register says
  assign req_ready  = reset ? ready_int : '0;
  assign pb_wen     = pb_wen_reg;
  assign pb_write   = pb_write_reg;
  assign word_count = word_count_reg;

endmodule

// File: tb/tb_probe_buffer_arbiter.sv
// Bench for probe_buffer_arbiter: scripted table, directed corner sequences and
// randomized traffic, all compared against a transaction-level reference model.
module tb_probe_buffer_arbiter;

  localparam int NR = 4;
  localparam int MB = 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 enable;
  logic [NR-1:0]        req_valid;
  logic [NR*64-1:0]     req_data;
  logic [NR-1:0]        req_ready;
  logic                 pb_wen;
  logic [63:0]          pb_write;
  logic [31:0]          word_count;

  always #5 clock = ~clock;

  probe_buffer_arbiter #(
    .NUM_REQ   (NR),
    .MAX_BURST (MB),
    .HDR_MAGIC (16'hB0F0)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .pb_wen     (pb_wen),
    .pb_write   (pb_write),
    .word_count (word_count)
  );

  int checks   = 0;
  int failures = 0;

  // reference model
  int          m_phase;   // 0 waiting, 1 header owed, 2 streaming
  int          m_owner, m_ptr, m_last, m_nwords;
  logic [31:0] m_count;
  logic        exp_wen;
  logic [63:0] exp_write;

  int            seq [NR];
  int            acc_total;
  logic [NR-1:0] obs_ready;
  int            hdr_n;
  logic [63:0]   hdr_val [8];

  function automatic logic [63:0] word(input int i, input int s);
    return {16'hDA7A, 8'(i), 8'h00, 32'(s)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_ptr = NR - 1; m_last = -1; m_nwords = 0;
    m_count = 0; exp_wen = 1'b0; exp_write = '0;
  endtask

  function automatic logic [NR-1:0] model_ready();
    if (reset && enable && m_phase == 2) return NR'(1) << m_owner;
    return '0;
  endfunction

  task automatic finish_burst();
    $display("burst src=%0d words=%0d count=%0d", m_owner, m_nwords, m_count);
    m_ptr = m_owner; m_last = m_owner; m_nwords = 0; m_phase = 0;
  endtask

  task automatic model_edge();
    int w;
    int c;
    if (!reset) begin
      model_reset();
      return;
    end
    case (m_phase)
      0: begin
        exp_wen = 1'b0;
        if (enable && req_valid != 0) begin
          w = -1;
          for (int k = 1; k <= NR; k++) begin
            c = (m_ptr + k) % NR;
            if (w < 0 && req_valid[c]) w = c;
          end
          m_owner = w;
          m_phase = (m_last < 0 || w != m_last) ? 1 : 2;
        end
      end
      1: begin
        exp_wen   = 1'b1;
        exp_write = {16'hB0F0, 8'(m_owner), 8'h00, m_count};
        m_phase   = 2;
      end
      default: begin
        if (enable && req_valid[m_owner]) begin
          exp_wen   = 1'b1;
          exp_write = req_data[64*m_owner +: 64];
          m_count   = m_count + 32'd1;
          m_nwords++;
          if (m_nwords == MB) finish_burst();
        end else begin
          exp_wen = 1'b0;
          finish_burst();
        end
      end
    endcase
  endtask

  // One clock of stimulus; starts and ends at a falling edge.
  task automatic cycle(input bit rstn, input bit en, input logic [NR-1:0] valid);
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] acc;
    reset = rstn; enable = en; req_valid = valid;
    for (int i = 0; i < NR; i++) req_data[64*i +: 64] = word(i, seq[i]);
    #1;
    exp_ready = model_ready();
    obs_ready = req_ready;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    acc = valid & exp_ready;
    model_edge();
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        seq[i]++;
        acc_total++;
      end
    end
    @(posedge clock);
    #1;
    check("pb_wen", 64'(pb_wen), 64'(exp_wen));
    check("pb_write", pb_write, exp_write);
    check("word_count", 64'(word_count), 64'(m_count));
    if (pb_wen === 1'b1 && pb_write[63:48] == 16'hB0F0) begin
      if (hdr_n < 8) hdr_val[hdr_n] = pb_write;
      hdr_n++;
    end
    @(negedge clock);
  endtask

  typedef struct {
    bit          rstn;
    bit          en;
    logic [3:0]  valid;
    logic [3:0]  exp_ready;
    bit          exp_wen;
    logic [63:0] exp_write;
    logic [31:0] exp_count;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] vr;
    bit r_rstn, r_en;
    reset = 1'b0; enable = 1'b0; req_valid = '0; req_data = '0;
    for (int i = 0; i < NR; i++) seq[i] = 0;
    acc_total = 0; hdr_n = 0; obs_ready = '0;
    model_reset();

    // Req0 streams A,B,C with a header; then a headerless burst cut by enable
    tbl[0]  = '{1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 64'h0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b0, 64'h0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b1, 64'hB0F0_0000_0000_0000, 32'd0};
    tbl[3]  = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 64'hDA7A_0000_0000_0000, 32'd1};
    tbl[4]  = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 64'hDA7A_0000_0000_0001, 32'd2};
    tbl[5]  = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 64'hDA7A_0000_0000_0002, 32'd3};
    tbl[6]  = '{1'b1, 1'b1, 4'h0, 4'h1, 1'b0, 64'hDA7A_0000_0000_0002, 32'd3};
    tbl[7]  = '{1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 64'hDA7A_0000_0000_0002, 32'd3};
    tbl[8]  = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b0, 64'hDA7A_0000_0000_0002, 32'd3};
    tbl[9]  = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 64'hDA7A_0000_0000_0003, 32'd4};
    tbl[10] = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 64'hDA7A_0000_0000_0004, 32'd5};
    tbl[11] = '{1'b1, 1'b0, 4'h1, 4'h0, 1'b0, 64'hDA7A_0000_0000_0004, 32'd5};
    tbl[12] = '{1'b1, 1'b1, 4'h1, 4'h0, 1'b0, 64'hDA7A_0000_0000_0004, 32'd5};
    tbl[13] = '{1'b1, 1'b1, 4'h1, 4'h1, 1'b1, 64'hDA7A_0000_0000_0005, 32'd6};
    tbl[14] = '{1'b1, 1'b1, 4'h0, 4'h1, 1'b0, 64'hDA7A_0000_0000_0005, 32'd6};

    @(negedge clock);
    for (int v = 0; v < 15; v++) begin
      cycle(tbl[v].rstn, tbl[v].en, tbl[v].valid);
      check("tbl_ready", 64'(obs_ready), 64'(tbl[v].exp_ready));
      check("tbl_wen", 64'(pb_wen), 64'(tbl[v].exp_wen));
      check("tbl_write", pb_write, tbl[v].exp_write);
      check("tbl_count", 64'(word_count), 64'(tbl[v].exp_count));
      $display("vec %0d ready=%b wen=%b write=%h count=%0d", v, obs_ready, pb_wen, pb_write, word_count);
    end

    // 20 words from req0: bursts of MB, one header only
    cycle(1'b0, 1'b1, 4'h0);
    acc_total = 0; hdr_n = 0;
    for (int n = 0; n < 100 && acc_total < 20; n++) cycle(1'b1, 1'b1, 4'h1);
    cycle(1'b1, 1'b1, 4'h0);
    cycle(1'b1, 1'b1, 4'h0);
    check("long_count", 64'(word_count), 64'd20);
    check("long_headers", 64'(hdr_n), 64'd1);
    $display("long stream words=%0d headers=%0d", word_count, hdr_n);

    // Req1 and req3 contend: alternating grants, header every burst
    cycle(1'b0, 1'b1, 4'h0);
    hdr_n = 0;
    for (int n = 0; n < 60; n++) cycle(1'b1, 1'b1, 4'b1010);
    cycle(1'b1, 1'b1, 4'h0);
    cycle(1'b1, 1'b1, 4'h0);
    check("rr_hdr_cnt_ge4", 64'(hdr_n >= 4), 64'd1);
    for (int h = 0; h < 4; h++)
      check("rr_hdr_src", 64'(hdr_val[h][47:40]), 64'((h % 2 == 0) ? 1 : 3));
    $display("round robin headers=%0d", hdr_n);

    // Reset in the middle of a burst
    cycle(1'b0, 1'b1, 4'h0);
    acc_total = 0;
    for (int n = 0; n < 50 && acc_total < 5; n++) cycle(1'b1, 1'b1, 4'h1);
    cycle(1'b0, 1'b1, 4'h1);
    check("rst_ready", 64'(obs_ready), 64'd0);
    check("rst_wen", 64'(pb_wen), 64'd0);
    check("rst_write", pb_write, 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    hdr_n = 0;
    for (int n = 0; n < 10 && hdr_n == 0; n++) cycle(1'b1, 1'b1, 4'h1);
    check("rst_hdr_seen", 64'(hdr_n), 64'd1);
    check("rst_hdr", hdr_val[0], 64'hB0F0_0000_0000_0000);
    cycle(1'b1, 1'b1, 4'h0);
    cycle(1'b1, 1'b1, 4'h0);
    $display("mid-burst reset header=%h", hdr_val[0]);

    // word_count wrap
    cycle(1'b0, 1'b1, 4'h0);
    cycle(1'b1, 1'b1, 4'h0);
    force dut.word_count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.word_count_reg;
    m_count = 32'hFFFF_FFFF;
    check("wrap_preset", 64'(word_count), 64'hFFFF_FFFF);
    hdr_n = 0;
    cycle(1'b1, 1'b1, 4'h1);
    cycle(1'b1, 1'b1, 4'h1);
    cycle(1'b1, 1'b1, 4'h1);
    cycle(1'b1, 1'b1, 4'h0);
    check("wrap_count", 64'(word_count), 64'd0);
    check("wrap_hdr_pre", hdr_val[0], 64'hB0F0_0000_FFFF_FFFF);
    hdr_n = 0;
    cycle(1'b1, 1'b1, 4'h4);
    cycle(1'b1, 1'b1, 4'h4);
    check("wrap_hdr_seen", 64'(hdr_n), 64'd1);
    check("wrap_hdr_post", hdr_val[0], 64'hB0F0_0200_0000_0000);
    cycle(1'b1, 1'b1, 4'h4);
    cycle(1'b1, 1'b1, 4'h0);
    $display("wrap header=%h count=%0d", hdr_val[0], word_count);

    // Randomized traffic with occasional enable drops and resets
    vr = '0;
    for (int n = 0; n < 1500; n++) begin
      r_rstn = ($urandom_range(0, 199) != 0);
      r_en   = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NR; i++)
        if ($urandom_range(0, 7) == 0) vr[i] = ~vr[i];
      cycle(r_rstn, r_en, vr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
